tx_word_arbiter: RTL and testbench
==================================

Name: tx_word_arbiter

Overview:
- Shares the single uart_tx word channel between two requesters: source 0 (trading decisions, the l2t stage output) and source 1 (telemetry words such as latency stamps and stall counts).
- Strict priority to source 0, with a starvation guard that forces a source 1 grant after STARVE_MAX consecutive source 0 grants.
- Registered single-entry output slot. Valid/ready on both sides.
- Sits between pipeline_regs/telemetry logic and uart_tx. The uart_tx ready, masked by sink_allow, drives m_ready.

Parameters:
- DW, 32, data word width
- STARVE_MAX, 4, consecutive source 0 grants tolerated while source 1 waits (must be at least 1)
- CNT_W, 32, width of the grant and starvation-event counters

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s0_valid  in  1  decision word valid
- s0_data  in  DW  decision word
- s0_ready  out  1  decision word accepted this cycle when high with s0_valid
- s1_valid  in  1  telemetry word valid
- s1_data  in  DW  telemetry word
- s1_ready  out  1  telemetry word accepted this cycle when high with s1_valid
- m_valid  out  1  output word valid (to uart_tx data_valid)
- m_data  out  DW  output word (to uart_tx data_in)
- m_src  out  1  source of the current m_data (0 or 1)
- m_ready  in  1  downstream accept
- grant_cnt0  out  CNT_W  words accepted from source 0
- grant_cnt1  out  CNT_W  words accepted from source 1
- starve_events  out  CNT_W  forced source 1 grants made while s0_valid was high

Behaviour:
- Reset, asynchronous and immediate: m_valid=0, m_data=0, m_src=0, starve_cnt=0, all counters=0. Any pending word is discarded. No partial transfer survives.
- Slot states:
  - EMPTY: m_valid=0.
  - FULL: m_valid=1.
  - slot_free = !m_valid | m_ready.
- Winner selection, combinational, evaluated every cycle:
  - force1 = s1_valid & (starve_cnt >= STARVE_MAX).
  - sel1 = s1_valid & (!s0_valid | force1).
  - sel0 = s0_valid & !sel1.
- Ready outputs:
  - s0_ready = slot_free & sel0.
  - s1_ready = slot_free & sel1.
  - At most one ready is high per cycle. A ready never depends on its own valid except through selection.
- Accept: a source is accepted when its valid and ready are both high.
  - Next cycle: m_valid=1, m_data=accepted word, m_src=source. Latency is exactly 1 cycle.
- No accept while slot_free=1: next cycle m_valid=0. m_data and m_src hold their last values.
- Hold (m_valid=1, m_ready=0): m_data and m_src stay stable. Both readies are 0.
- Simultaneous drain and refill (m_valid=1, m_ready=1, new accept): back-to-back words, 1 word/clock sustained.
- starve_cnt, saturating at STARVE_MAX:
  - Increments on a source 0 accept while s1_valid=1.
  - Clears on a source 1 accept.
  - Clears in any cycle with s1_valid=0.
  - Otherwise holds.
- Counters (all wrap modulo 2^CNT_W):
  - grant_cnt0 increments on a source 0 accept.
  - grant_cnt1 increments on a source 1 accept.
  - starve_events increments on a source 1 accept with force1=1 and s0_valid=1.
- Sources must hold valid and data stable until accepted. The arbiter does not check this.
- No combinational path from m_ready to m_valid or m_data. The paths from m_ready to s*_ready are permitted.

Test Plan:
- Reset then idle; s0 presents 0xDEADBEEF with m_ready=1 -> s0_ready=1 same cycle; next cycle m_valid=1, m_data=0xDEADBEEF, m_src=0; grant_cnt0=1.
- s0 and s1 both valid continuously, m_ready=1, STARVE_MAX=4 -> grant sequence 0,0,0,0,1 repeating; after 10 grants: grant_cnt0=8, grant_cnt1=2, starve_events=2.
- Word 0x00000011 in slot with m_ready=0 for 5 cycles while s0 and s1 assert -> m_data stays 0x00000011, both readies 0; m_ready=1 -> next word loaded the following cycle with no bubble.
- s1 only, words 0x1..0x3, m_ready=1 -> three consecutive m_valid cycles from source 1; starve_events stays 0; starve_cnt stays 0.
- s0 streaming, s1 drops valid after 2 losses, then reasserts -> starve_cnt restarts at 0, so the forced grant comes only after 4 further source 0 grants.
- rst_n pulsed low mid-stream with m_valid=1 -> m_valid=0 and all counters 0 asynchronously; the first word after release arrives with latency 1.

Source files
------------

// File: rtl/tx_word_arbiter.sv
// tx_word_arbiter
// Shares the single uart_tx word channel between two requesters.
//   source 0 : trading decisions from the l2t stage (strict priority)
//   source 1 : telemetry words (latency stamps, stall counts)
// A starvation guard forces a source 1 grant after STARVE_MAX consecutive
// source 0 grants made while source 1 was waiting. The output is a single
// registered slot with valid/ready on both sides, sustaining one word per
// clock when downstream keeps m_ready high.
module tx_word_arbiter #(
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s0_valid,
  input  logic [DW-1:0]    s0_data,
  output logic             s0_ready,
  input  logic             s1_valid,
  input  logic [DW-1:0]    s1_data,
  output logic             s1_ready,
  output logic             m_valid,
  output logic [DW-1:0]    m_data,
  output logic             m_src,
  input  logic             m_ready,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic [CNT_W-1:0] starve_events
);

  // Starvation counter only needs to reach STARVE_MAX, where it saturates.
  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t   slot_q;
  logic [SW-1:0] starve_cnt;

  logic slot_free;
  logic force1;
  logic sel0;
  logic sel1;
  logic acc0;
  logic acc1;

  // m_valid comes straight from the slot register, so m_ready never reaches it
  // combinationally.
  assign m_valid = (slot_q == FULL);

  // Winner selection and ready generation, re-evaluated every cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    slot_free = 1'b0;
    force1    = 1'b0;
    sel0      = 1'b0;
    sel1      = 1'b0;

    slot_free = !m_valid || m_ready;
    force1    = s1_valid && (starve_cnt >= STARVE_LIM);
    sel1      = s1_valid && (!s0_valid || force1);
    sel0      = s0_valid && !sel1;
  end

  assign s0_ready = slot_free && sel0;
  assign s1_ready = slot_free && sel1;
  assign acc0     = s0_valid && s0_ready;
  assign acc1     = s1_valid && s1_ready;

  // Output slot: load the accepted word, drain to EMPTY when nothing refills,
  // hold data and source while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= EMPTY;
      m_data <= '0;
      m_src  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (acc0) begin
        slot_q <= FULL;
        m_data <= s0_data;
        m_src  <= 1'b0;
      end else if (acc1) begin
        slot_q <= FULL;
        m_data <= s1_data;
        m_src  <= 1'b1;
      end else if (slot_free) begin
        slot_q <= EMPTY;
      end
    end
  end

  // Consecutive source 0 grants while source 1 waits; any source 1 grant or a
  // cycle with source 1 idle restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else begin
      if (acc1 || !s1_valid) begin
        starve_cnt <= '0;
      end else if (acc0 && (starve_cnt < STARVE_LIM)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

  // Grant and starvation-event statistics, wrapping at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0    <= '0;
      grant_cnt1    <= '0;
      starve_events <= '0;
    end else begin
      if (acc0) begin
        grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      end
      if (acc1) begin
        grant_cnt1 <= grant_cnt1 + CNT_W'(1);
      end
      if (acc1 && force1 && s0_valid) begin
        starve_events <= starve_events + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tx_word_arbiter.sv
// Self-checking bench for tx_word_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// transaction-level model of the arbiter.
module tb_tx_word_arbiter;

  localparam int DW = 32;
  localparam int SM = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s0_valid, s1_valid, m_ready;
  logic [DW-1:0] s0_data, s1_data;
  logic          s0_ready, s1_ready, m_valid, m_src;
  logic [DW-1:0] m_data;
  logic [CW-1:0] grant_cnt0, grant_cnt1, starve_events;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tx_word_arbiter #(.DW(DW), .STARVE_MAX(SM), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s0_valid      (s0_valid),
    .s0_data       (s0_data),
    .s0_ready      (s0_ready),
    .s1_valid      (s1_valid),
    .s1_data       (s1_data),
    .s1_ready      (s1_ready),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_src         (m_src),
    .m_ready       (m_ready),
    .grant_cnt0    (grant_cnt0),
    .grant_cnt1    (grant_cnt1),
    .starve_events (starve_events)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the slot content, the length of the current run of
  // source 0 wins that source 1 sat through, and the three statistics.
  // ---------------------------------------------------------------------------
  logic          mdl_valid;
  logic [DW-1:0] mdl_data;
  logic          mdl_src;
  int            mdl_wait_run;
  logic [CW-1:0] mdl_g0, mdl_g1, mdl_se;
  logic          took0, took1;      // source accepted at the last edge
  logic          exp_r0, exp_r1;

  always_comb begin
    exp_r0 = 1'b0;
    exp_r1 = 1'b0;
    if (!mdl_valid || m_ready) begin
      if (s1_valid && (!s0_valid || mdl_wait_run >= SM)) exp_r1 = 1'b1;
      else if (s0_valid)                                 exp_r0 = 1'b1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_valid    <= 1'b0;
      mdl_data     <= '0;
      mdl_src      <= 1'b0;
      mdl_wait_run <= 0;
      mdl_g0       <= '0;
      mdl_g1       <= '0;
      mdl_se       <= '0;
      took0        <= 1'b0;
      took1        <= 1'b0;
    end else begin
      took0 <= exp_r0;
      took1 <= exp_r1;
      if (exp_r0) begin
        mdl_valid <= 1'b1;
        mdl_data  <= s0_data;
        mdl_src   <= 1'b0;
        mdl_g0    <= mdl_g0 + 1;
      end else if (exp_r1) begin
        mdl_valid <= 1'b1;
        mdl_data  <= s1_data;
        mdl_src   <= 1'b1;
        mdl_g1    <= mdl_g1 + 1;
        if (s0_valid) mdl_se <= mdl_se + 1;
      end else if (m_ready) begin
        mdl_valid <= 1'b0;
      end
      if (!s1_valid || exp_r1)                 mdl_wait_run <= 0;
      else if (exp_r0 && mdl_wait_run < SM)    mdl_wait_run <= mdl_wait_run + 1;
    end
  end

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("m_valid",       32'(m_valid),  32'(mdl_valid));
      check("m_data",        m_data,        mdl_data);
      check("m_src",         32'(m_src),    32'(mdl_src));
      check("s0_ready",      32'(s0_ready), 32'(exp_r0));
      check("s1_ready",      32'(s1_ready), 32'(exp_r1));
      check("grant_cnt0",    grant_cnt0,    mdl_g0);
      check("grant_cnt1",    grant_cnt1,    mdl_g1);
      check("starve_events", starve_events, mdl_se);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Give every source whose word was just taken a fresh data value.
  task automatic refresh_accepted();
    if (took0) s0_data = $urandom;
    if (took1) s1_data = $urandom;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    m_ready  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  logic got_src[16];

  initial begin
    rst_n    = 1'b0;
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    m_ready  = 1'b0;
    s0_data  = '0;
    s1_data  = '0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Reset state.
    check("rst m_valid", 32'(m_valid), 32'd0);
    check("rst m_data",  m_data,       32'd0);
    check("rst g0",      grant_cnt0,   32'd0);
    check("rst se",      starve_events, 32'd0);

    // Single decision word, latency 1.
    s0_valid = 1'b1;
    s0_data  = 32'hDEADBEEF;
    m_ready  = 1'b1;
    #1;
    check("beef s0_ready", 32'(s0_ready), 32'd1);
    step();
    s0_valid = 1'b0;
    check("beef m_valid", 32'(m_valid), 32'd1);
    check("beef m_data",  m_data,       32'hDEADBEEF);
    check("beef m_src",   32'(m_src),   32'd0);
    check("beef g0",      grant_cnt0,   32'd1);
    step();

    // Both sources saturating the channel: 0,0,0,0,1 repeating.
    do_reset();
    m_ready  = 1'b1;
    s0_valid = 1'b1;
    s1_valid = 1'b1;
    s0_data  = 32'h1000;
    s1_data  = 32'h2000;
    for (int i = 0; i < 10; i++) begin
      step();
      got_src[i] = m_src;
      refresh_accepted();
    end
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    for (int i = 0; i < 10; i++) check($sformatf("prio src%0d", i), 32'(got_src[i]), 32'((i % 5) == 4));
    check("prio g0", grant_cnt0,    32'd8);
    check("prio g1", grant_cnt1,    32'd2);
    check("prio se", starve_events, 32'd2);
    step();

    // Stall with a word in the slot, then release with no bubble.
    s0_valid = 1'b1;
    s0_data  = 32'h00000011;
    step();
    m_ready  = 1'b0;
    s0_data  = 32'h00000022;
    s1_valid = 1'b1;
    s1_data  = 32'h00000033;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold m_data", m_data,        32'h00000011);
      check("hold rdy",    32'({s0_ready, s1_ready}), 32'd0);
      step();
    end
    m_ready = 1'b1;
    step();
    s0_valid = 1'b0;
    check("release m_data", m_data,      32'h00000022);
    check("release m_valid", 32'(m_valid), 32'd1);
    step();
    s1_valid = 1'b0;
    check("release s1 word", m_data, 32'h00000033);
    step();

    // Telemetry only: three back-to-back source 1 words.
    do_reset();
    m_ready  = 1'b1;
    s1_valid = 1'b1;
    s1_data  = 32'h1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("s1only m_valid", 32'(m_valid), 32'd1);
      check("s1only m_src",   32'(m_src),   32'd1);
      check("s1only m_data",  m_data,       32'(i));
      s1_data = 32'(i + 1);
    end
    s1_valid = 1'b0;
    check("s1only se", starve_events, 32'd0);
    step();

    // Source 1 withdraws after two losses: the run restarts from zero.
    s0_valid = 1'b1;
    s1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s1_valid = (i != 2);
      step();
      got_src[i] = m_src;
      refresh_accepted();
    end
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    for (int i = 0; i < 8; i++) check($sformatf("drop src%0d", i), 32'(got_src[i]), 32'(i == 7));
    step();

    // Asynchronous reset in the middle of a stream.
    s0_valid = 1'b1;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst m_valid", 32'(m_valid), 32'd0);
    check("arst g0",      grant_cnt0,   32'd0);
    check("arst g1",      grant_cnt1,   32'd0);
    s0_valid = 1'b0;
    step();
    #3 rst_n = 1'b1;
    step();
    s0_valid = 1'b1;
    s0_data  = 32'hCAFE0001;
    step();
    s0_valid = 1'b0;
    check("arst first m_valid", 32'(m_valid), 32'd1);
    check("arst first m_data",  m_data,       32'hCAFE0001);
    check("arst first g0",      grant_cnt0,   32'd1);
    step();

    // Randomized traffic; sources hold words until taken (source 1 may
    // occasionally withdraw, as telemetry is allowed to).
    for (int i = 0; i < 4000; i++) begin
      refresh_accepted();
      if (took0 || !s0_valid) s0_valid = ($urandom_range(0, 99) < 60);
      if (took1 || !s1_valid) s1_valid = ($urandom_range(0, 99) < 50);
      else if ($urandom_range(0, 99) < 3) s1_valid = 1'b0;
      m_ready = ($urandom_range(0, 99) < 75);
      step();
    end
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
